regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-issue register file.
- Provides XLEN-wide registers (count set by NREGS) with two combinational read ports and one posedge write-back port.
- Adds a per-register busy scoreboard that tracks in-flight producers, so the decode stage gets source/destination hazard stall signals directly.
- Sits between decode/issue and write-back in the pipelined core.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must satisfy NREGS <= 2**AW.
- AW, 5, register address width.
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never marked busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset).
- wb_en  in  1  write-back strobe.
- wb_addr  in  AW  write-back destination.
- wb_data  in  XLEN  write-back data.
- iss_valid  in  1  decode presents an instruction for issue.
- iss_rd_en  in  1  issuing instruction writes a destination.
- iss_rd  in  AW  destination of issuing instruction.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- flush  in  1  pipeline squash; clears all busy bits.
- rs1_data  out  XLEN  read port 1 data.
- rs2_data  out  XLEN  read port 2 data.
- rs1_busy  out  1  rs1 has a pending producer.
- rs2_busy  out  1  rs2 has a pending producer.
- stall  out  1  issue must be held this cycle.
- pending_cnt  out  AW+1  number of set busy bits.

Behaviour:
- Reset (rst=0 at rising edge):
  - All registers, busy bits and pending_cnt go to 0.
  - Reset overrides wb, issue and flush in the same cycle.
  - Mid-operation reset discards everything in flight.
- Reads are combinational.
  - Address 0 with ZERO_REG=1 returns 0.
  - Address >= NREGS returns 0 and busy=0.
- Write: on rising edge, if wb_en and wb_addr valid (< NREGS, and non-zero when ZERO_REG=1), regs[wb_addr] <= wb_data.
  - Writes to invalid addresses are dropped silently.
  - Write clears busy[wb_addr].
- rsN_busy = busy[rsN_addr], unless the bypass condition below applies.
- Issue handshake:
  - stall = iss_valid & (rs1_busy | rs2_busy | (iss_rd_en & busy[iss_rd])).
  - The last term is the WAW hazard. Issue fires when iss_valid & ~stall & ~flush.
  - On fire with iss_rd_en and a valid non-zero iss_rd, busy[iss_rd] is set next edge.
  - iss_valid=0 forces stall=0.
  - The source is expected to hold its instruction while stall=1; the block keeps no issue state.
- Simultaneous events:
  - Fire sets and wb clears the same register: the set wins, since the new producer is tracked.
  - flush with wb: all busy bits cleared and the write still commits.
  - flush with iss_valid: the issue is not recorded.
- pending_cnt:
  - Registered; updated each edge by +1 (set only), -1 (clear of a busy reg only), or 0 (both or neither).
  - Flush sets it to 0.
  - It equals the popcount of the busy bits at all times and never wraps.
  - Clearing an already-clear bit does not decrement.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding. If wb_en and wb_addr == rsN_addr (valid address), rsN_data = wb_data in the same cycle.
  - rsN_busy is forced 0 and the WAW term is ignored for that register, so a dependent instruction issues in the write-back cycle with zero bubble.
- Undefined:
  - Reads return the old register value until the edge after the write.
  - Busy stays set during the write-back cycle, giving a 1-cycle stall.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wb_en=1, wb_addr=3, wb_data=0xFFFF_FFFF -> rs1_data(addr 3)=0, pending_cnt=0, stall=0.
- Basic write/read: wb x5=0x1234_5678, then read rs1=5, rs2=0 -> rs1_data=0x1234_5678, rs2_data=0. Then wb x0=0xDEAD -> read x0 still 0.
- RAW hazard:
  - Issue rd=7, so pending_cnt=1. Next cycle iss_valid with rs1=7 -> stall=1.
  - wb x7=0xAA: with REGFILE_BYPASS_EN, stall=0 and rs1_data=0xAA the same cycle; without it, stall=1 that cycle and 0 the next.
- WAW and simultaneous set/clear:
  - Issue rd=9, then in one cycle wb x9 while firing an issue with rd=4 -> busy[9]=0, busy[4]=1, pending_cnt=1.
  - Same-register case: fire rd=9 while wb x9 -> busy[9] stays 1, pending_cnt unchanged.
- Flush: set busy on x1, x2, x3 (pending_cnt=3); assert flush with iss_valid, rd=4 and wb x10=0x55 -> pending_cnt=0, no busy bits set, x10 reads 0x55.
- Bounds: with NREGS=16, AW=5, wb_addr=20 -> no register changes; read rs1=20 -> data 0, busy 0; issue rd=20 -> pending_cnt unchanged.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: XLEN x NREGS register file with two combinational read
// ports, one write-back port and a per-register busy scoreboard that gives the
// decode stage its RAW/WAW stall directly.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding; a
// write-back to a source register clears its hazard in the same cycle).
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            iss_valid,
    input  logic            iss_rd_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            flush,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            stall,
    output logic [AW:0]     pending_cnt
);

    // Storage spans the full address space so every AW-bit index is in range;
    // entries at or above NREGS are never written and never read.
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;

    logic wb_ok;
    logic hit1, hit2, hit_rd;
    logic waw;
    logic fire;
    logic set_en, set_new, clr_real;

    // Address is backed by a real, writable register (x0 excluded when hardwired).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wb_ok = wb_en & addr_ok(wb_addr);

`ifdef REGFILE_BYPASS_EN
    assign hit1   = wb_ok & (wb_addr == rs1_addr);
    assign hit2   = wb_ok & (wb_addr == rs2_addr);
    assign hit_rd = wb_ok & (wb_addr == iss_rd);
`else
    assign hit1   = 1'b0;
    assign hit2   = 1'b0;
    assign hit_rd = 1'b0;
`endif

    // Read ports, hazard flags and the issue stall.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        waw      = 1'b0;
        if (hit1) begin
            rs1_data = wb_data;
        end else if (addr_ok(rs1_addr)) begin
            rs1_data = regs_q[rs1_addr];
            rs1_busy = busy_q[rs1_addr];
        end
        if (hit2) begin
            rs2_data = wb_data;
        end else if (addr_ok(rs2_addr)) begin
            rs2_data = regs_q[rs2_addr];
            rs2_busy = busy_q[rs2_addr];
        end
        if (iss_rd_en && addr_ok(iss_rd) && !hit_rd) begin
            waw = busy_q[iss_rd];
        end
        stall = iss_valid & (rs1_busy | rs2_busy | waw);
    end

    assign fire   = iss_valid & ~stall & ~flush;
    assign set_en = fire & iss_rd_en & addr_ok(iss_rd);

    // Scoreboard next state: set beats clear on the same register; the counter
    // only moves on real 0->1 / 1->0 transitions so it tracks the popcount.
    always_comb begin
        busy_d   = busy_q;
        set_new  = set_en & ~busy_q[iss_rd];
        clr_real = wb_ok & busy_q[wb_addr] & ~(set_en && (iss_rd == wb_addr));
        cnt_d    = cnt_q + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_real};
        if (wb_ok) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end
    end

    // Scoreboard and pending-count registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Register array write-back; flush does not cancel a committing write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_ok) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (NREGS=16, AW=5 so addresses 16..31
// are out of range). Expectations follow the build's REGFILE_BYPASS_EN setting.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            iss_valid;
    logic            iss_rd_en;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            flush;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            stall;
    logic [AW:0]     pending_cnt;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(16), .AW(AW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .flush(flush),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .stall(stall), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_en     = 1'b0;
        iss_valid = 1'b0;
        iss_rd_en = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b0; idle();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hFFFF_FFFF;
        iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
        tick(); tick();

        // reset held with a write pending: write must be discarded
        rst = 1'b1; idle(); rs1_addr = 5'd3; #1;
        check("rst_data", rs1_data, 32'h0);
        check("rst_cnt", pending_cnt, 6'd0);
        check("rst_stall", stall, 1'b0);

        // basic write/read and hardwired x0
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678; tick();
        idle(); rs1_addr = 5'd5; rs2_addr = 5'd0; #1;
        check("rd_x5", rs1_data, 32'h1234_5678);
        check("rd_x0", rs2_data, 32'h0);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_DEAD; tick();
        idle(); rs2_addr = 5'd0; #1;
        check("x0_wr_ign", rs2_data, 32'h0);

        // RAW hazard on x7
        iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = 5'd7; rs1_addr = 5'd0; #1;
        check("iss7_stall", stall, 1'b0);
        tick();
        check("iss7_cnt", pending_cnt, 6'd1);
        iss_rd_en = 1'b0; rs1_addr = 5'd7; #1;
        check("raw_stall", stall, 1'b1);
        check("raw_busy", rs1_busy, 1'b1);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_00AA; #1;
`ifdef REGFILE_BYPASS_EN
        check("wb7_stall", stall, 1'b0);
        check("wb7_data", rs1_data, 32'h0000_00AA);
`else
        check("wb7_stall", stall, 1'b1);
        check("wb7_data", rs1_data, 32'h0);
`endif
        tick();
        wb_en = 1'b0; #1;
        check("post7_stall", stall, 1'b0);
        check("post7_data", rs1_data, 32'h0000_00AA);
        check("post7_cnt", pending_cnt, 6'd0);
        idle();

        // WAW bookkeeping: clear x9 while setting x4 in one edge
        iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = 5'd9; rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        check("iss9_cnt", pending_cnt, 6'd1);
        iss_rd = 5'd4; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99; #1;
        check("x_stall", stall, 1'b0);
        tick();
        idle(); rs1_addr = 5'd9; rs2_addr = 5'd4; #1;
        check("x_busy9", rs1_busy, 1'b0);
        check("x_busy4", rs2_busy, 1'b1);
        check("x_cnt", pending_cnt, 6'd1);
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = 5'd4; #1;
        check("waw_stall", stall, 1'b1);
        tick();
        check("waw_cnt", pending_cnt, 6'd1);

        // same-register set/clear on a busy x9
        iss_rd = 5'd9; tick();
        check("iss9b_cnt", pending_cnt, 6'd2);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h77; #1;
`ifdef REGFILE_BYPASS_EN
        check("same_stall", stall, 1'b0);
`else
        check("same_stall", stall, 1'b1);
`endif
        tick();
        idle(); rs1_addr = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
        check("same_busy9", rs1_busy, 1'b1);
        check("same_cnt", pending_cnt, 6'd2);
`else
        check("same_busy9", rs1_busy, 1'b0);
        check("same_cnt", pending_cnt, 6'd1);
`endif

        // flush clears, then rebuild x1..x3 and flush with issue + write-back
        flush = 1'b1; tick(); idle(); #1;
        check("fl0_cnt", pending_cnt, 6'd0);
        iss_valid = 1'b1; iss_rd_en = 1'b1; rs1_addr = 5'd0;
        for (int r = 1; r <= 3; r++) begin
            iss_rd = AW'(r);
            tick();
        end
        check("set3_cnt", pending_cnt, 6'd3);
        flush = 1'b1; iss_rd = 5'd4;
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h55;
        tick();
        idle(); rs1_addr = 5'd1; rs2_addr = 5'd4; #1;
        check("fl_cnt", pending_cnt, 6'd0);
        check("fl_busy1", rs1_busy, 1'b0);
        check("fl_busy4", rs2_busy, 1'b0);
        rs1_addr = 5'd10; #1;
        check("fl_x10", rs1_data, 32'h55);

        // out-of-range addresses
        wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'h0BAD; tick();
        idle(); rs1_addr = 5'd20; rs2_addr = 5'd5; #1;
        check("oob_data", rs1_data, 32'h0);
        check("oob_busy", rs1_busy, 1'b0);
        check("oob_x5", rs2_data, 32'h1234_5678);
        iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = 5'd20; rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        check("oob_cnt", pending_cnt, 6'd0);

        // decrement only on a real clear
        iss_rd = 5'd5; tick(); idle();
        check("inc_cnt", pending_cnt, 6'd1);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1; tick();
        check("dec_cnt", pending_cnt, 6'd0);
        tick();
        check("noclr_cnt", pending_cnt, 6'd0);

        // mid-operation reset
        idle(); iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = 5'd6; tick();
        check("pre_rst_cnt", pending_cnt, 6'd1);
        rst = 1'b0; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66; tick();
        rst = 1'b1; idle(); rs1_addr = 5'd5; rs2_addr = 5'd6; #1;
        check("mid_rst_cnt", pending_cnt, 6'd0);
        check("mid_rst_x5", rs1_data, 32'h0);
        check("mid_rst_x6", rs2_data, 32'h0);
        check("mid_rst_busy", rs2_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
